// File: rtl/ramp_seq_pkg.sv
// Shared types and constants for the ramp sequencer.
package ramp_seq_pkg;

   localparam int DEF_PERIOD_W = 8;
   localparam int DEF_STEPS_W  = 12;
   localparam int DEF_HOLD_W   = 8;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_TRI  = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ARM  = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      ARM  = ST_ARM,
      RUN  = ST_RUN,
      HOLD = ST_HOLD,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/ramp_seq_timer.sv
// Loadable saturating down-counter; load wins over enable, never wraps below zero.
module ramp_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero,
   output logic         one
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);
   assign one  = (count == W'(1));

endmodule

// File: rtl/ramp_seq_ctrl.sv
// Ramp control sequencer: ARM -> RUN (timed delta strobes) -> HOLD -> DONE.
// Optional macro RAMP_SEQ_LOOP_EN adds a loop input that re-arms from DONE.
module ramp_seq_ctrl
   import ramp_seq_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int STEPS_W  = DEF_STEPS_W,
   parameter int HOLD_W   = DEF_HOLD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
`ifdef RAMP_SEQ_LOOP_EN
   input  logic                loop,
`endif
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [STEPS_W-1:0]  cfg_steps,
   input  logic [HOLD_W-1:0]   cfg_hold,
   output logic                ramp_enb,
   output logic [1:0]          Y,
   output logic                delta,
   output logic                busy,
   output logic                done
);

   state_t              state, next_state;
   logic [1:0]          mode_q;
   logic [PERIOD_W-1:0] period_q;
   logic [STEPS_W-1:0]  steps_q, steps_left;
   logic [HOLD_W-1:0]   hold_q;

   logic per_zero, per_one, hold_zero, hold_one;
   logic accept, strobe, last_strobe, run_like, delta_nxt, loop_req;
   logic [1:0] next_mode;

`ifdef RAMP_SEQ_LOOP_EN
   assign loop_req = loop;
`else
   assign loop_req = 1'b0;
`endif

   assign accept      = (state == IDLE) && start && !abort;
   assign strobe      = (state == RUN) && per_zero;
   assign last_strobe = strobe && (steps_left == STEPS_W'(1));

   ramp_seq_timer #(.W(PERIOD_W)) u_period (
      .clk      (clk),
      .rst      (rst_n),
      .load     ((state == ARM) || strobe),
      .en       (state == RUN),
      .load_val (period_q),
      .zero     (per_zero),
      .one      (per_one)
   );

   ramp_seq_timer #(.W(HOLD_W)) u_hold (
      .clk      (clk),
      .rst      (rst_n),
      .load     (last_strobe),
      .en       (state == HOLD),
      .load_val (hold_q),
      .zero     (hold_zero),
      .one      (hold_one)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = (cfg_steps != '0) ? ARM : DONE;
         ARM:  next_state = RUN;
         RUN:  if (last_strobe) next_state = (hold_q != '0) ? HOLD : DONE;
         HOLD: if (hold_one || hold_zero) next_state = DONE;
         DONE: next_state = loop_req ? ARM : IDLE;
         default: next_state = IDLE;
      endcase
      if (abort && (state != IDLE))
         next_state = IDLE;
   end

   // Outputs are registered, so delta is predicted for the cycle after this edge.
   always_comb begin
      delta_nxt = 1'b0;
      case (state)
         ARM:     delta_nxt = (period_q == '0);
         RUN:     delta_nxt = per_zero ? (period_q == '0) : per_one;
         default: delta_nxt = 1'b0;
      endcase
      delta_nxt = delta_nxt && (next_state == RUN);
   end

   assign next_mode = accept ? cfg_mode : mode_q;
   assign run_like  = (next_state == ARM) || (next_state == RUN) || (next_state == HOLD);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state      <= IDLE;
         mode_q     <= '0;
         period_q   <= '0;
         steps_q    <= '0;
         hold_q     <= '0;
         steps_left <= '0;
         ramp_enb   <= 1'b0;
         Y          <= MODE_OFF;
         delta      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            mode_q   <= cfg_mode;
            period_q <= cfg_period;
            steps_q  <= cfg_steps;
            hold_q   <= cfg_hold;
         end
         if (state == ARM)
            steps_left <= steps_q;
         else if (strobe && (steps_left != '0))
            steps_left <= steps_left - 1'b1;
         ramp_enb <= run_like;
         Y        <= run_like ? next_mode : MODE_OFF;
         delta    <= delta_nxt;
         busy     <= (next_state != IDLE);
         done     <= (next_state == DONE);
      end
   end

endmodule

// File: doc/ramp_seq_ctrl.md
Name: ramp_seq_ctrl

Overview:
Sequencer that drives the Ramp generator's control inputs (ramp_enb, Y, delta) from a latched segment configuration: ramp mode, step period, step count and hold time. Sits between the pattern-control logic and Ramp. Issues a timed burst of delta strobes, holds the final level, then signals completion. Start/done handshake, with abort.

Parameters:
PERIOD_W, 8, width of cfg_period (cycles between delta strobes, minus 1)
STEPS_W, 12, width of cfg_steps (number of delta strobes per pass)
HOLD_W, 8, width of cfg_hold (cycles to hold after last strobe)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-high reset (1 = reset)
start  input  1  pulse; latch cfg_* and begin a pass (ignored while busy)
abort  input  1  return to IDLE next cycle; has priority over start
cfg_mode  input  2  ramp mode forwarded to Y during the pass
cfg_period  input  PERIOD_W  strobe spacing P; delta every P+1 cycles
cfg_steps  input  STEPS_W  strobe count N
cfg_hold  input  HOLD_W  hold cycles H after last strobe
ramp_enb  output  1  Ramp enable
Y  output  2  Ramp mode select
delta  output  1  one-cycle step strobe to Ramp
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- All outputs registered. Reset (rst_n=1 at clk edge): state IDLE, ramp_enb=0, Y=2'b00, delta=0, busy=0, done=0, all counters and shadow regs 0.
- cfg_* sampled only on the accepted start edge into shadow regs. Later cfg changes have no effect on the running pass.
- States: IDLE, ARM, RUN, HOLD, DONE.
- IDLE: outputs idle values.
  - start=1, N!=0 -> ARM.
  - start=1, N==0 -> DONE, with ramp_enb kept 0 throughout.
- ARM: exactly 1 cycle. ramp_enb=1, Y=mode, delta=0. Period counter loaded with P. -> RUN.
- RUN: ramp_enb=1, Y=mode.
  - Index RUN cycles from 0. delta=1 on cycles P, 2P+1, 3P+2, ...; P=0 gives delta every cycle.
  - Steps counter decrements on each strobe. Period counter reloads with P.
  - After the Nth strobe cycle -> HOLD if H!=0, else DONE.
- HOLD: ramp_enb=1, Y=mode, delta=0 for exactly H cycles -> DONE.
- DONE: 1 cycle. done=1, busy=1, ramp_enb=0, delta=0, Y=2'b00. -> IDLE.
- start while busy: ignored, not queued. start in the DONE cycle: ignored.
- abort=1 in any non-IDLE state: next cycle IDLE, idle outputs, no done pulse. abort in IDLE: no effect. abort+start same cycle: abort wins.
- rst_n mid-pass: same as abort, and shadow regs are also cleared.
- Counters never wrap. N and H use full width; max N = 2^STEPS_W-1.

Optional Feature:
RAMP_SEQ_LOOP_EN:
- Defined: adds input loop (1 bit), sampled each DONE cycle. loop=1 in DONE -> ARM (re-run with the same shadow config; done still pulses once per pass). loop=0 -> IDLE. abort ends the loop.
- Not defined: no loop port; DONE always -> IDLE.

Decomposition:
- Package ramp_seq_pkg holds:
  - state enum (IDLE/ARM/RUN/HOLD/DONE)
  - 2-bit mode constants for Y
  - default widths
- One natural sub-module: ramp_seq_timer, a loadable down-counter with load/enable/zero flag. Instantiated twice, for the period and hold counters.

Test Plan:
1. Reset then idle: rst_n=1 for 2 cycles, then 0 -> ramp_enb=0, Y=00, delta=0, busy=0, done=0.
2. start at cycle 0, mode=01, P=2, N=3, H=0 -> ARM cycle 1; RUN from cycle 2; delta at cycles 4,7,10; done=1 at cycle 11; busy 1..11; ramp_enb 1..10.
3. mode=10, P=0, N=4, H=2 -> delta cycles 2-5, hold cycles 6-7 (ramp_enb=1, delta=0), done at 8.
4. start with N=0 -> done pulse at cycle 1, ramp_enb never asserted, delta never asserted.
5. Abort at cycle 6 of case 2 -> cycle 7 IDLE, ramp_enb=0, no done. Second start during RUN is ignored: strobe timing unchanged.
6. With RAMP_SEQ_LOOP_EN, loop=1, P=1, N=2, H=0 -> done every 6 cycles. Drop loop before the second DONE -> IDLE after exactly 2 passes.
